// File: rtl/controller.sv
// rtl/controller.sv - multicycle MIPS control FSM with INT/NMI acknowledge sequencing
module controller (
   input  logic       Clk,
   input  logic       Reset,
   input  logic [5:0] Op,
   input  logic [5:0] funct,
   input  logic       INT,
   input  logic       NMI,
   input  logic       INTD,
   output logic       isBranch,
   output logic       PCWrite,
   output logic       lorD,
   output logic       MemWrite,
   output logic       MemtoReg,
   output logic       IRWrite,
   output logic       INA,
   output logic [1:0] aluControl,
   output logic [1:0] ALUSrcB,
   output logic       PCSource,
   output logic       ALUSrcA,
   output logic       RegWrite,
   output logic       RegDst,
   output logic       isInterrupted
);

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
      S_EXECUTE, S_ALUWB, S_BRANCH, S_ADDIEXE, S_ADDIWB, S_INTACK
   } state_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;

   state_t state_q, state_d;
   logic   int_q, int_d;
   logic   boundary;
   logic   pending;

   function automatic logic [1:0] funct_alu(input logic [5:0] f);
      case (f)
         6'b100010: funct_alu = 2'b01;
         6'b100100: funct_alu = 2'b10;
         6'b100101: funct_alu = 2'b11;
         default:   funct_alu = 2'b00;
      endcase
   endfunction

   assign pending = NMI | (INT & ~INTD);

   always_comb begin
      state_d  = state_q;
      int_d    = int_q;
      boundary = 1'b0;
      case (state_q)
         S_FETCH:   state_d = S_DECODE;
         S_DECODE: begin
            case (Op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXECUTE;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDIEXE;
               default:      boundary = 1'b1;
            endcase
         end
         S_MEMADR:  state_d = (Op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD: state_d = S_MEMWB;
         S_EXECUTE: state_d = S_ALUWB;
         S_ADDIEXE: state_d = S_ADDIWB;
         S_MEMWB, S_MEMWRITE, S_ALUWB, S_BRANCH, S_ADDIWB: boundary = 1'b1;
         S_INTACK:  state_d = S_FETCH;
         default:   state_d = S_FETCH;
      endcase
      // Interrupts are only arbitrated between instructions; in-service blocks even NMI.
      if (boundary) begin
         if (pending && !int_q) begin
            state_d = S_INTACK;
            int_d   = 1'b1;
         end else begin
            state_d = S_FETCH;
            if (!INT && !NMI) int_d = 1'b0;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= S_FETCH;
         int_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         int_q   <= int_d;
      end
   end

   always_comb begin
      isBranch      = 1'b0;
      PCWrite       = 1'b0;
      lorD          = 1'b0;
      MemWrite      = 1'b0;
      MemtoReg      = 1'b0;
      IRWrite       = 1'b0;
      INA           = 1'b0;
      aluControl    = 2'b00;
      ALUSrcB       = 2'b00;
      PCSource      = 1'b0;
      ALUSrcA       = 1'b0;
      RegWrite      = 1'b0;
      RegDst        = 1'b0;
      isInterrupted = 1'b0;
      if (!Reset) begin
         isInterrupted = int_q;
         case (state_q)
            S_FETCH: begin
               IRWrite = 1'b1;
               PCWrite = 1'b1;
               ALUSrcB = 2'b01;
            end
            S_DECODE:   ALUSrcB = 2'b11;
            S_MEMADR, S_ADDIEXE: begin
               ALUSrcA = 1'b1;
               ALUSrcB = 2'b10;
            end
            S_MEMREAD:  lorD = 1'b1;
            S_MEMWB: begin
               MemtoReg = 1'b1;
               RegWrite = 1'b1;
            end
            S_MEMWRITE: begin
               lorD     = 1'b1;
               MemWrite = 1'b1;
            end
            S_EXECUTE: begin
               ALUSrcA    = 1'b1;
               aluControl = funct_alu(funct);
            end
            S_ALUWB: begin
               RegDst   = 1'b1;
               RegWrite = 1'b1;
            end
            S_BRANCH: begin
               ALUSrcA    = 1'b1;
               aluControl = 2'b01;
               PCSource   = 1'b1;
               isBranch   = 1'b1;
            end
            S_ADDIWB:   RegWrite = 1'b1;
            S_INTACK: begin
               INA     = 1'b1;
               PCWrite = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_controller.sv
// tb/tb_controller.sv - directed scoreboard bench for the multicycle control FSM
module tb_controller;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic [5:0] Op = 6'b0;
   logic [5:0] funct = 6'b0;
   logic       INT = 1'b0;
   logic       NMI = 1'b0;
   logic       INTD = 1'b0;
   logic       isBranch, PCWrite, lorD, MemWrite, MemtoReg, IRWrite, INA;
   logic [1:0] aluControl, ALUSrcB;
   logic       PCSource, ALUSrcA, RegWrite, RegDst, isInterrupted;

   int n_cmp = 0;
   int n_bad = 0;
   logic [15:0] exp_q[$];

   controller dut (
      .Clk(Clk), .Reset(Reset), .Op(Op), .funct(funct),
      .INT(INT), .NMI(NMI), .INTD(INTD),
      .isBranch(isBranch), .PCWrite(PCWrite), .lorD(lorD), .MemWrite(MemWrite),
      .MemtoReg(MemtoReg), .IRWrite(IRWrite), .INA(INA), .aluControl(aluControl),
      .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
      .RegDst(RegDst), .isInterrupted(isInterrupted)
   );

   always #5 Clk = ~Clk;

   // Packed order: br pcw lord mw m2r irw ina alu[1:0] srcb[1:0] pcs srca rw rd isint
   function automatic logic [15:0] mk(input bit br, pcw, lord, mw, m2r, irw, ina,
                                      input logic [1:0] alu, srcb,
                                      input bit pcs, srca, rw, rd);
      return {br, pcw, lord, mw, m2r, irw, ina, alu, srcb, pcs, srca, rw, rd, 1'b0};
   endfunction

   localparam logic [15:0] ZERO = 16'h0;
   logic [15:0] E_FETCH, E_DECODE, E_MEMADR, E_MEMREAD, E_MEMWB, E_MEMWRITE;
   logic [15:0] E_ALUWB, E_BRANCH, E_ADDIWB, E_INTACK;

   function automatic logic [15:0] e_exec(input logic [1:0] alu);
      return mk(0,0,0,0,0,0,0, alu, 2'b00, 0,1,0,0);
   endfunction

   task automatic cyc(input string tag, input logic [15:0] e, input bit isint);
      logic [15:0] got, want;
      exp_q.push_back(e | {15'b0, isint});
      @(negedge Clk);
      got = {isBranch, PCWrite, lorD, MemWrite, MemtoReg, IRWrite, INA, aluControl,
             ALUSrcB, PCSource, ALUSrcA, RegWrite, RegDst, isInterrupted};
      want = exp_q.pop_front();
      n_cmp++;
      assert (got === want) else begin
         n_bad++;
         $error("FAIL %s: observed %b expected %b", tag, got, want);
      end
      @(posedge Clk);
      #1;
   endtask

   initial begin
      E_FETCH    = mk(0,1,0,0,0,1,0, 2'b00, 2'b01, 0,0,0,0);
      E_DECODE   = mk(0,0,0,0,0,0,0, 2'b00, 2'b11, 0,0,0,0);
      E_MEMADR   = mk(0,0,0,0,0,0,0, 2'b00, 2'b10, 0,1,0,0);
      E_MEMREAD  = mk(0,0,1,0,0,0,0, 2'b00, 2'b00, 0,0,0,0);
      E_MEMWB    = mk(0,0,0,0,1,0,0, 2'b00, 2'b00, 0,0,1,0);
      E_MEMWRITE = mk(0,0,1,1,0,0,0, 2'b00, 2'b00, 0,0,0,0);
      E_ALUWB    = mk(0,0,0,0,0,0,0, 2'b00, 2'b00, 0,0,1,1);
      E_BRANCH   = mk(1,0,0,0,0,0,0, 2'b01, 2'b00, 1,1,0,0);
      E_ADDIWB   = mk(0,0,0,0,0,0,0, 2'b00, 2'b00, 0,0,1,0);
      E_INTACK   = mk(0,1,0,0,0,0,1, 2'b00, 2'b00, 0,0,0,0);

      Reset = 1'b1; Op = 6'b100011; INT = 1'b1; NMI = 1'b1;
      @(posedge Clk); #1;
      cyc("reset0", ZERO, 0);
      cyc("reset1", ZERO, 0);
      INT = 1'b0; NMI = 1'b0; Reset = 1'b0;

      Op = 6'b100011;
      cyc("lw_fetch",   E_FETCH,   0);
      cyc("lw_decode",  E_DECODE,  0);
      cyc("lw_memadr",  E_MEMADR,  0);
      cyc("lw_memread", E_MEMREAD, 0);
      cyc("lw_memwb",   E_MEMWB,   0);

      Op = 6'b000000; funct = 6'b100010;
      cyc("sub_fetch",  E_FETCH,         0);
      cyc("sub_decode", E_DECODE,        0);
      cyc("sub_exec",   e_exec(2'b01),   0);
      cyc("sub_aluwb",  E_ALUWB,         0);
      funct = 6'b100101;
      cyc("or_fetch",   E_FETCH,         0);
      cyc("or_decode",  E_DECODE,        0);
      cyc("or_exec",    e_exec(2'b11),   0);
      cyc("or_aluwb",   E_ALUWB,         0);
      funct = 6'b111111;
      cyc("dflt_fetch", E_FETCH,         0);
      cyc("dflt_decode", E_DECODE,       0);
      cyc("dflt_exec",  e_exec(2'b00),   0);
      cyc("dflt_aluwb", E_ALUWB,         0);

      Op = 6'b000100;
      cyc("beq_fetch",  E_FETCH,  0);
      cyc("beq_decode", E_DECODE, 0);
      cyc("beq_branch", E_BRANCH, 0);

      Op = 6'b101011; INT = 1'b1; INTD = 1'b1;
      cyc("swm_fetch",  E_FETCH,    0);
      cyc("swm_decode", E_DECODE,   0);
      cyc("swm_memadr", E_MEMADR,   0);
      cyc("swm_memwr",  E_MEMWRITE, 0);
      INTD = 1'b0;
      cyc("sw_fetch",   E_FETCH,    0);
      cyc("sw_decode",  E_DECODE,   0);
      cyc("sw_memadr",  E_MEMADR,   0);
      cyc("sw_memwr",   E_MEMWRITE, 0);
      cyc("sw_intack",  E_INTACK,   1);
      INT = 1'b0;

      Op = 6'b001000; NMI = 1'b1; INTD = 1'b1;
      cyc("addi_n_fetch",  E_FETCH,  1);
      cyc("addi_n_decode", E_DECODE, 1);
      cyc("addi_n_exe",    E_MEMADR, 1);
      cyc("addi_n_wb",     E_ADDIWB, 1);
      NMI = 1'b0; Op = 6'b111111;
      cyc("unsup_fetch",   E_FETCH,  1);
      cyc("unsup_decode",  E_DECODE, 1);

      Op = 6'b001000; NMI = 1'b1;
      cyc("addi_fetch",  E_FETCH,  0);
      cyc("addi_decode", E_DECODE, 0);
      cyc("addi_exe",    E_MEMADR, 0);
      cyc("addi_wb",     E_ADDIWB, 0);
      cyc("nmi_intack",  E_INTACK, 1);
      NMI = 1'b0;

      Op = 6'b100011;
      cyc("rst_fetch",  E_FETCH,  1);
      cyc("rst_decode", E_DECODE, 1);
      cyc("rst_memadr", E_MEMADR, 1);
      Reset = 1'b1;
      cyc("rst_in_memread", ZERO, 0);
      cyc("rst_held",       ZERO, 0);
      Reset = 1'b0;
      cyc("post_rst_fetch",  E_FETCH,  0);
      cyc("post_rst_decode", E_DECODE, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
